// File: rtl/credit_sender_push.sv
// ---------------------------------------------------------------------------
// credit_sender_push
//
// Push-side transmitter for a credit-flow-controlled FIFO. Items accepted
// from a local valid/ready source are forwarded as one-cycle push_valid /
// push_data pulses, each spending one credit. Credits come back one per
// push_credit pulse. The block also runs the sender/receiver reset handshake
// (RESET -> WAIT_RX -> INIT -> ACTIVE) and works only in the push_clk domain.
//
// Parameters
//   WIDTH        data width
//   MAX_CREDITS  largest credit count the counter can hold
//   CW           credit-count width, $clog2(MAX_CREDITS+1)
//
// Ports
//   push_clk                in   only clock
//   push_rst                in   synchronous active-high reset
//   push_receiver_in_reset  in   far end is in reset
//   push_sender_in_reset    out  this sender is in RESET
//   push_credit_stall       out  receiver should hold credit returns
//   push_credit             in   one-cycle pulse returning one credit
//   push_valid              out  registered one-cycle push pulse
//   push_data               out  data that goes with push_valid
//   credit_initial_push     in   credit count loaded in INIT (clamped)
//   credit_withhold_push    in   credits held back from spending (dynamic)
//   credit_count_push       out  credits currently held
//   credit_available_push   out  spendable credits (count minus withhold)
//   credit_error            out  sticky credit overflow flag
//   in_valid/in_ready/in_data   upstream handshake
//
// Build option
//   CREDIT_SENDER_SKID_EN  when defined, a 2-entry skid buffer decouples
//                          in_ready from the credit logic (in_ready is then
//                          registered, in -> push_valid latency is 2 cycles).
//                          When undefined, in_ready is combinational and the
//                          latency is 1 cycle.
// ---------------------------------------------------------------------------
module credit_sender_push #(
  parameter int WIDTH       = 8,
  parameter int MAX_CREDITS = 16,
  parameter int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic             push_clk,
  input  logic             push_rst,
  input  logic             push_receiver_in_reset,
  output logic             push_sender_in_reset,
  output logic             push_credit_stall,
  input  logic             push_credit,
  output logic             push_valid,
  output logic [WIDTH-1:0] push_data,
  input  logic [CW-1:0]    credit_initial_push,
  input  logic [CW-1:0]    credit_withhold_push,
  output logic [CW-1:0]    credit_count_push,
  output logic [CW-1:0]    credit_available_push,
  output logic             credit_error,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_WAIT_RX = 2'd1,
    ST_INIT    = 2'd2,
    ST_ACTIVE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             error_q, error_d;
  logic             push_valid_q, push_valid_d;
  logic [WIDTH-1:0] push_data_q, push_data_d;

  logic [CW-1:0]    available_s;
  logic             can_spend_s;
  logic             active_s;     // ACTIVE and the receiver is still up
  logic             rx_drop_s;    // ACTIVE -> WAIT_RX this cycle
  logic             src_valid_s;
  logic [WIDTH-1:0] src_data_s;
  logic             send_s;
  logic [CW-1:0]    init_load_s;

  // Spendable credits and send qualification
  always_comb begin
    if (count_q > credit_withhold_push) begin
      available_s = count_q - credit_withhold_push;
    end else begin
      available_s = {CW{1'b0}};
    end
    can_spend_s = (available_s != {CW{1'b0}});
    // A receiver reset seen while ACTIVE blocks sending in that very cycle,
    // so nothing is pushed into a FIFO whose far end is going down.
    active_s  = (state_q == ST_ACTIVE) && !push_receiver_in_reset;
    rx_drop_s = (state_q == ST_ACTIVE) && push_receiver_in_reset;
    send_s    = active_s && can_spend_s && src_valid_s;
    if (credit_initial_push > MAX_C) begin
      init_load_s = MAX_C;
    end else begin
      init_load_s = credit_initial_push;
    end
  end

`ifdef CREDIT_SENDER_SKID_EN
  logic [WIDTH-1:0] skid_mem_q [2];
  logic [WIDTH-1:0] skid_mem_d [2];
  logic             skid_rd_q, skid_rd_d;
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             skid_push_s;
  logic             skid_wr_s;

  // Skid buffer bookkeeping: write at tail, drain head on send, flush on
  // receiver reset.
  always_comb begin
    skid_mem_d  = skid_mem_q;
    skid_rd_d   = skid_rd_q;
    skid_cnt_d  = skid_cnt_q;
    skid_push_s = in_valid && in_ready_q;
    skid_wr_s   = skid_rd_q ^ skid_cnt_q[0];
    if (rx_drop_s) begin
      skid_rd_d  = 1'b0;
      skid_cnt_d = 2'd0;
    end else begin
      if (skid_push_s) begin
        skid_mem_d[skid_wr_s] = in_data;
      end else begin
        skid_mem_d[skid_wr_s] = skid_mem_q[skid_wr_s];
      end
      if (send_s) begin
        skid_rd_d = ~skid_rd_q;
      end else begin
        skid_rd_d = skid_rd_q;
      end
      skid_cnt_d = skid_cnt_q + {1'b0, skid_push_s} - {1'b0, send_s};
    end
    // Ready is computed from next occupancy so a registered ready can never
    // let a third item in.
    in_ready_d = (skid_cnt_d != 2'd2);
  end

  // Skid buffer registers
  always_ff @(posedge push_clk) begin
    if (push_rst) begin
      skid_mem_q[0] <= {WIDTH{1'b0}};
      skid_mem_q[1] <= {WIDTH{1'b0}};
      skid_rd_q     <= 1'b0;
      skid_cnt_q    <= 2'd0;
      in_ready_q    <= 1'b0;
    end else begin
      skid_mem_q[0] <= skid_mem_d[0];
      skid_mem_q[1] <= skid_mem_d[1];
      skid_rd_q     <= skid_rd_d;
      skid_cnt_q    <= skid_cnt_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign src_valid_s = (skid_cnt_q != 2'd0);
  assign src_data_s  = skid_mem_q[skid_rd_q];
  assign in_ready    = in_ready_q;
`else
  assign src_valid_s = in_valid;
  assign src_data_s  = in_data;
  assign in_ready    = active_s && can_spend_s;
`endif

  // Handshake state machine: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        if (!push_receiver_in_reset) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_WAIT_RX;
        end
      end
      ST_INIT: begin
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (push_receiver_in_reset) begin
          state_d = ST_WAIT_RX;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Credit counter, overflow flag and registered push outputs
  always_comb begin
    count_d      = count_q;
    error_d      = error_q;
    push_valid_d = send_s;
    push_data_d  = push_data_q;
    if (send_s) begin
      push_data_d = src_data_s;
    end else begin
      push_data_d = push_data_q;
    end
    case (state_q)
      ST_RESET: begin
        count_d = {CW{1'b0}};
      end
      ST_WAIT_RX: begin
        count_d = count_q;
      end
      ST_INIT: begin
        count_d = init_load_s;
      end
      ST_ACTIVE: begin
        if (push_receiver_in_reset) begin
          count_d = {CW{1'b0}};
        end else if (send_s && !push_credit) begin
          count_d = count_q - ONE_C;
        end else if (push_credit && !send_s) begin
          // A credit beyond capacity means the receiver over-returned;
          // saturate and flag it rather than wrap.
          if (count_q >= MAX_C) begin
            count_d = MAX_C;
            error_d = 1'b1;
          end else begin
            count_d = count_q + ONE_C;
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        count_d = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge push_clk) begin
    if (push_rst) begin
      state_q      <= ST_RESET;
      count_q      <= {CW{1'b0}};
      error_q      <= 1'b0;
      push_valid_q <= 1'b0;
      push_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      error_q      <= error_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
    end
  end

  assign push_sender_in_reset  = (state_q == ST_RESET);
  assign push_credit_stall     = (state_q != ST_ACTIVE);
  assign push_valid            = push_valid_q;
  assign push_data             = push_data_q;
  assign credit_count_push     = count_q;
  assign credit_available_push = available_s;
  assign credit_error          = error_q;

endmodule

// File: tb/tb_credit_sender_push.sv
// Self-checking bench for credit_sender_push (default build, no skid buffer).
// A behavioural model tracks credits as a plain integer and bring-up as a few
// flags; every cycle all outputs are compared against it.
module tb_credit_sender_push;
  localparam int WIDTH = 8;
  localparam int MAXC  = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             push_rst;
  logic             rxr;
  logic             sender_in_reset;
  logic             stall;
  logic             credit;
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic [CW-1:0]    init_credit;
  logic [CW-1:0]    withhold;
  logic [CW-1:0]    count;
  logic [CW-1:0]    avail;
  logic             error;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  always #5 clk = ~clk;

  credit_sender_push #(.WIDTH(WIDTH), .MAX_CREDITS(MAXC), .CW(CW)) dut (
    .push_clk              (clk),
    .push_rst              (push_rst),
    .push_receiver_in_reset(rxr),
    .push_sender_in_reset  (sender_in_reset),
    .push_credit_stall     (stall),
    .push_credit           (credit),
    .push_valid            (push_valid),
    .push_data             (push_data),
    .credit_initial_push   (init_credit),
    .credit_withhold_push  (withhold),
    .credit_count_push     (count),
    .credit_available_push (avail),
    .credit_error          (error),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data)
  );

  int total = 0;
  int bad   = 0;

  // reference model
  bit         m_in_rst;   // first cycle after reset
  bit         m_active;   // credits may be spent
  bit         m_init;     // one cycle away from loading credits
  int         m_count;
  bit         m_err;
  bit         m_pv;
  logic [7:0] m_pd;
  int         n_acc;
  int         n_pulse;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_avail();
    int w;
    w = int'(withhold);
    return (m_count > w) ? (m_count - w) : 0;
  endfunction

  task automatic m_reset();
    m_in_rst = 1'b1; m_active = 1'b0; m_init = 1'b0;
    m_count = 0; m_err = 1'b0; m_pv = 1'b0; m_pd = 8'd0;
  endtask

  // Compare every output, then advance the model across one clock edge.
  task automatic tick();
    int av;
    bit rdy;
    bit snd;
    #1;
    av  = m_avail();
    rdy = m_active && !rxr && (av > 0);
    check_val("sender_in_reset", sender_in_reset, m_in_rst);
    check_val("stall", stall, !m_active);
    check_val("count", count, m_count);
    check_val("available", avail, av);
    check_val("in_ready", in_ready, rdy);
    check_val("push_valid", push_valid, m_pv);
    check_val("push_data", push_data, m_pd);
    check_val("credit_error", error, m_err);
    if (push_valid) n_pulse++;
    snd = rdy && in_valid;
    if (push_rst) begin
      m_reset();
    end else begin
      m_pv = snd;
      if (snd) begin
        m_pd = in_data;
        n_acc++;
      end
      if (m_in_rst) begin
        m_in_rst = 1'b0;
      end else if (m_active) begin
        if (rxr) begin
          m_active = 1'b0;
          m_count  = 0;
        end else begin
          if (credit && !snd && m_count == MAXC) m_err = 1'b1;
          m_count = m_count - int'(snd) + int'(credit);
          if (m_count > MAXC) m_count = MAXC;
        end
      end else if (m_init) begin
        m_init   = 1'b0;
        m_active = 1'b1;
        m_count  = (int'(init_credit) > MAXC) ? MAXC : int'(init_credit);
      end else if (!rxr) begin
        m_init = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    push_rst = 1'b1; rxr = 1'b0; credit = 1'b0; init_credit = 5'd16;
    withhold = 5'd4; in_valid = 1'b0; in_data = 8'd0;
    m_reset();
    n_acc = 0; n_pulse = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    tick();

    // bring-up
    push_rst = 1'b0;
    repeat (3) tick();
    check_val("bringup_stall", stall, 0);
    check_val("bringup_count", count, 16);
    check_val("bringup_avail", avail, 12);

    // credit exhaustion: exactly 12 pulses carrying 0..11
    n_acc = 0; n_pulse = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = n_acc[7:0];
      tick();
    end
    in_valid = 1'b0;
    check_val("exhaust_pulses", n_pulse, 12);
    check_val("exhaust_count", count, 4);
    check_val("exhaust_avail", avail, 0);

    // simultaneous send and credit
    credit = 1'b1;
    repeat (6) tick();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    credit = 1'b0; in_valid = 1'b0;
    check_val("simul_count", count, 10);
    check_val("simul_valid", push_valid, 1);
    check_val("simul_data", push_data, 8'hA5);

    // overflow
    credit = 1'b1;
    repeat (7) tick();
    credit = 1'b0;
    check_val("ovf_count", count, 16);
    check_val("ovf_error", error, 1);
    repeat (3) tick();
    check_val("ovf_sticky", error, 1);

    // dynamic withhold
    in_valid = 1'b1;
    withhold = 5'd20;
    #1;
    check_val("withhold_avail", avail, 0);
    check_val("withhold_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    withhold = 5'd4;
    #1;
    check_val("restore_avail", avail, 12);
    tick();

    // receiver reset mid-stream
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 8'($urandom);
      tick();
    end
    rxr = 1'b1;
    tick();
    check_val("rxrst_valid", push_valid, 0);
    check_val("rxrst_count", count, 0);
    check_val("rxrst_stall", stall, 1);
    repeat (4) tick();
    rxr = 1'b0;
    repeat (2) tick();
    check_val("rxrst_reload", count, 16);
    check_val("rxrst_active", stall, 0);
    in_valid = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      credit   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) withhold = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 31) == 0) init_credit = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) rxr = ~rxr;
      push_rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    push_rst = 1'b0; rxr = 1'b0; credit = 1'b0; in_valid = 1'b0;
    tick();

    // push_rst clears the sticky error
    push_rst = 1'b1;
    tick();
    tick();
    check_val("rst_error", error, 0);
    check_val("rst_count", count, 0);
    check_val("rst_sender", sender_in_reset, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/credit_sender_push.md
# credit_sender_push

Credit-based push transmitter that drives the push side of a credit-flow-controlled FIFO, such as the credit-controlled CDC FIFO used in this design. It accepts data from a local valid/ready source and forwards one item per cycle as a `push_valid`/`push_data` pulse while it holds a spendable credit. It tracks credits returned on `push_credit` and performs the sender/receiver reset handshake. It sits entirely in the push clock domain, upstream of the FIFO.

## Interface
- `WIDTH`, 8, data width
- `MAX_CREDITS`, 16, maximum credits the counter can hold
- `CW`, `$clog2(MAX_CREDITS+1)` (5), credit-count width
- `push_clk`  in  1  clock; the block's only clock
- `push_rst`  in  1  reset; synchronous, active-high
- `push_receiver_in_reset`  in  1  receiver end is in reset
- `push_sender_in_reset`  out  1  this sender is in reset
- `push_credit_stall`  out  1  asks the receiver to hold credit returns
- `push_credit`  in  1  one-cycle pulse returning one credit
- `push_valid`  out  1  one-cycle push pulse; each pulse consumes one credit
- `push_data`  out  WIDTH  data that accompanies `push_valid`
- `credit_initial_push`  in  CW  credit count loaded at INIT
- `credit_withhold_push`  in  CW  credits held back from spending; dynamic
- `credit_count_push`  out  CW  credits currently held
- `credit_available_push`  out  CW  spendable credits
- `credit_error`  out  1  sticky flag for a credit overflow
- `in_valid`  in  1  upstream data is valid
- `in_ready`  out  1  upstream handshake accepted
- `in_data`  in  WIDTH  upstream data

## Operation
- **States:** RESET, WAIT_RX, INIT, ACTIVE.
  - `push_rst` forces RESET.
  - RESET → WAIT_RX unconditionally.
  - WAIT_RX → INIT when `push_receiver_in_reset` = 0.
  - INIT → ACTIVE, loading `count <= min(credit_initial_push, MAX_CREDITS)`.
  - ACTIVE → WAIT_RX when `push_receiver_in_reset` = 1. On this transition, `count <= 0`.
- **Status outputs:**
  - `push_sender_in_reset` = (state == RESET).
  - `push_credit_stall` = (state != ACTIVE).
- **Spendable credits:** `credit_available_push` = `count > withhold ? count - withhold : 0`. This is combinational from the count register and the withhold input.
- **Send:**
  - `send` = ACTIVE && `in_valid` && `available` != 0.
  - `in_ready` = ACTIVE && `available` != 0.
- **Count update:** `count_next = count - send + push_credit`. A simultaneous send and credit leaves the count unchanged.
- **Overflow:** a `push_credit` pulse at `count == MAX_CREDITS` with no send leaves `count` at `MAX_CREDITS` and sets `credit_error`. `credit_error` clears only on `push_rst`.
- **Credits outside ACTIVE:** `push_credit` pulses outside ACTIVE are ignored.

## Timing
- **Reset values:**
  - `push_sender_in_reset` = 1, `push_credit_stall` = 1.
  - `push_valid` = 0, `push_data` = 0.
  - `credit_count_push` = 0, `credit_available_push` = 0, `credit_error` = 0.
  - `in_ready` = 0.
- **Bring-up:** `push_rst` falls at edge N. With the receiver already out of reset, the state sequence is RESET at N, WAIT_RX at N+1, INIT at N+2, ACTIVE at N+3. The count is loaded at the N+3 edge.
- **Send latency:** `push_valid`/`push_data` are registered. A handshake accepted at edge N appears at edge N+1 for exactly one cycle.
- **Credit latency:** a credit pulse at edge N updates `credit_count_push` at N+1. It can enable a send in that same cycle N+1.
- **Throughput:** back-to-back sends at one per cycle are allowed while credits remain.
- **Receiver reset mid-stream:** if `push_receiver_in_reset` rises at edge N, `send` is 0 from N. `push_valid` is 0 at N+1, and the count is 0 at N+1.

## Configuration
- **`CREDIT_SENDER_SKID_EN`** defined: a 2-entry skid buffer sits between `in_*` and the send logic.
  - `in_ready` is registered as "buffer not full".
  - Sends drain the buffer head when `available` != 0.
  - Latency from `in` to `push_valid` becomes 2 cycles.
  - The buffer is flushed on `push_rst` and on the ACTIVE → WAIT_RX transition.
- **Undefined:** `in_ready` is combinational as described in Operation, with 1-cycle latency.

## Test plan
- **Bring-up:** initial = 16, withhold = 4, receiver out of reset; release `push_rst` → ACTIVE 3 cycles later, with `count` = 16 and `available` = 12.
- **Credit exhaustion:** `in_valid` held at 1, no credit returns → exactly 12 consecutive `push_valid` pulses carrying data 0..11. `in_ready` drops after the 12th; then `count` = 4 and `available` = 0.
- **Simultaneous send and credit:** `count` = 10, send and `push_credit` in the same cycle → `count` stays 10 and `push_valid` pulses.
- **Overflow:** `count` = 16, `push_credit` with no send → `count` stays 16, `credit_error` = 1, and it remains 1 until `push_rst`.
- **Receiver reset mid-stream:** `push_receiver_in_reset` pulses for 5 cycles during streaming → `push_valid` is 0 the next cycle, `count` = 0, `stall` = 1. After deassert, INIT then ACTIVE, with `count` reloaded to `credit_initial_push`.
- **Dynamic withhold:** withhold changes from 4 to 20 while `count` = 16 → `available` = 0 and `in_ready` = 0 immediately. Restoring withhold to 4 gives `available` = 12.
